// File: rtl/uart_tx_if.sv
// Byte handshake between the UART TX controller (master) and the serializer (slave).
// The master presents a byte with valid; the slave takes it when ready is high.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_data_ready;

  modport master (
    output tx_data,
    output tx_data_valid,
    input  tx_data_ready
  );

  modport slave (
    input  tx_data,
    input  tx_data_valid,
    output tx_data_ready
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: accepts bytes over a valid/ready handshake and shifts them out
// LSB first as START, 8 data bits, optional parity and one or two STOP bits.
module uart_tx_serializer #(
  parameter int unsigned CLK_FRE   = 27,
  parameter int unsigned BAUD_RATE = 115200,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  uart_tx_if.slave   bus,
  output logic       tx_busy,
  output logic       tx_pin
);

  localparam int unsigned CyclesPerBit = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int unsigned CntW         = (CyclesPerBit < 2) ? 1 : $clog2(CyclesPerBit);

  if (CyclesPerBit < 2) begin : gen_bad_baud
    $error("uart_tx_serializer: fewer than 2 clock cycles per bit");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : gen_bad_stop
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end
  if (PARITY > 2) begin : gen_bad_parity
    $error("uart_tx_serializer: PARITY must be 0, 1 or 2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic            pin_q, pin_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            bit_end;

  assign bit_end = (cnt_q == CntW'(CyclesPerBit - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + CntW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pin_d   = pin_q;
    ready_d = ready_q;
    busy_d  = busy_q;

    unique case (state_q)
      StIdle: begin
        // ready rises here on the first cycle out of reset
        cnt_d   = '0;
        bit_d   = '0;
        pin_d   = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (bus.tx_data_valid && ready_q) begin
          shift_d = bus.tx_data;
          par_d   = (PARITY == 1) ? ~^bus.tx_data : ^bus.tx_data;
          state_d = StStart;
          pin_d   = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end

      StStart: begin
        if (bit_end) begin
          state_d = StData;
          pin_d   = shift_q[0];
        end
      end

      StData: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? StParity : StStop;
            pin_d   = (PARITY != 0) ? par_q : 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            pin_d   = shift_q[1];
          end
        end
      end

      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          pin_d   = 1'b1;
        end
      end

      StStop: begin
        if (bit_end) begin
          if (bit_q == 3'(STOP_BITS - 1)) begin
            state_d = StIdle;
            bit_d   = '0;
            pin_d   = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        bit_d   = '0;
        pin_d   = 1'b1;
        ready_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      pin_q   <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      pin_q   <= pin_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.tx_data_ready = ready_q;
  assign tx_busy           = busy_q;
  assign tx_pin            = pin_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four instances at 10 cycles/bit covering no parity, even,
// odd and two stop bits, checked cycle by cycle against a frame model built from bit lists.
module tb_uart_tx_serializer;

  localparam int C = 10;  // 1 MHz / 100 kbaud

  function automatic int cfg_par(input int i);
    return (i == 1) ? 2 : (i == 2) ? 1 : 0;
  endfunction

  function automatic int cfg_stop(input int i);
    return (i == 3) ? 2 : 1;
  endfunction

  logic       clk;
  logic [3:0] rst_v;
  logic [3:0] valid_v;
  logic [3:0] ready_v;
  logic [3:0] busy_v;
  logic [3:0] pin_v;
  logic [7:0] data_a [4];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    uart_tx_if u_if ();
    assign u_if.tx_data       = data_a[g];
    assign u_if.tx_data_valid = valid_v[g];
    assign ready_v[g]         = u_if.tx_data_ready;

    uart_tx_serializer #(
      .CLK_FRE  (1),
      .BAUD_RATE(100000),
      .PARITY   (cfg_par(g)),
      .STOP_BITS(cfg_stop(g))
    ) u_dut (
      .clk    (clk),
      .rst    (rst_v[g]),
      .bus    (u_if.slave),
      .tx_busy(busy_v[g]),
      .tx_pin (pin_v[g])
    );
  end

  // Expected line level k cycles after the start bit begins.
  function automatic logic model_pin(input int idx, input logic [7:0] d, input int k);
    int   slot;
    logic odd_ones;
    slot     = k / C;
    odd_ones = ($countones(d) % 2) == 1;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
    if (cfg_par(idx) != 0 && slot == 9) return (cfg_par(idx) == 2) ? odd_ones : !odd_ones;
    return 1'b1;
  endfunction

  function automatic int frame_len(input int idx);
    return C * (10 + ((cfg_par(idx) != 0) ? 1 : 0) + (cfg_stop(idx) - 1));
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send(input int idx, input logic [7:0] d, input string name);
    int n = 0;
    while (ready_v[idx] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({name, " ready"}, 32'(ready_v[idx]), 32'd1);
    data_a[idx]  = d;
    valid_v[idx] = 1'b1;
    @(posedge clk);
  endtask

  // Call right after the acceptance edge. mode 0: drop valid; 1: hold valid with nxt;
  // 2: jitter valid/data then hold valid with nxt; 3: jitter then drop valid.
  task automatic frame_check(input int idx, input logic [7:0] d, input int mode,
                             input logic [7:0] nxt, input string name,
                             output logic [7:0] dec, output logic s9, output int len);
    int L;
    int bad;
    int s;
    L   = frame_len(idx);
    bad = 0;
    len = -1;
    dec = 'x;
    s9  = 1'bx;
    for (int k = 0; k < L + 20; k++) begin
      @(negedge clk);
      if (ready_v[idx] === 1'b1) begin
        len = k;
        break;
      end
      if (pin_v[idx] !== model_pin(idx, d, k)) bad++;
      if (busy_v[idx] !== 1'b1) bad++;
      if (k % C == C / 2) begin
        s = k / C;
        if (s >= 1 && s <= 8) dec[s-1] = pin_v[idx];
        if (s == 9) s9 = pin_v[idx];
      end
      case (mode)
        0: if (k == 0) valid_v[idx] = 1'b0;
        1: if (k == 0) data_a[idx] = nxt;
        default: begin
          if (k < L - 20) begin
            valid_v[idx] = 1'($urandom_range(0, 1));
            data_a[idx]  = (k % 2 == 1) ? 8'hFF : 8'($urandom);
          end else begin
            valid_v[idx] = (mode == 2);
            data_a[idx]  = nxt;
          end
        end
      endcase
    end
    chk({name, " wave"}, 32'(bad), 32'd0);
    chk({name, " len"}, 32'(len), 32'(L));
    chk({name, " end pin/busy"}, 32'({pin_v[idx], busy_v[idx]}), 32'b10);
  endtask

  task automatic idle_check(input int idx, input int n, input string name);
    int bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (pin_v[idx] !== 1'b1 || busy_v[idx] !== 1'b0) bad++;
    end
    chk(name, 32'(bad), 32'd0);
  endtask

  typedef struct {
    int         idx;
    logic [7:0] d;
    logic       exp_s9;   // line level in the 10th bit period
    int         exp_len;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vt [7];
    logic [7:0] dec;
    logic       s9;
    int         len;
    int         idx;
    logic [7:0] d;

    vt[0] = '{0, 8'h55, 1'b1, 100};
    vt[1] = '{1, 8'h07, 1'b1, 110};
    vt[2] = '{2, 8'h07, 1'b0, 110};
    vt[3] = '{3, 8'hFF, 1'b1, 110};
    vt[4] = '{1, 8'h00, 1'b0, 110};
    vt[5] = '{2, 8'h00, 1'b1, 110};
    vt[6] = '{0, 8'hA5, 1'b1, 100};

    rst_v   = 4'hF;
    valid_v = 4'h0;
    for (int i = 0; i < 4; i++) data_a[i] = 8'h00;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset%0d pin", i), 32'(pin_v[i]), 32'd1);
      chk($sformatf("reset%0d busy", i), 32'(busy_v[i]), 32'd0);
      chk($sformatf("reset%0d ready", i), 32'(ready_v[i]), 32'd0);
    end
    rst_v = 4'h0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk($sformatf("post-reset%0d ready", i), 32'(ready_v[i]), 32'd1);

    // Table-driven single frames
    for (int i = 0; i < 7; i++) begin
      send(vt[i].idx, vt[i].d, $sformatf("vec%0d", i));
      frame_check(vt[i].idx, vt[i].d, 0, 8'h00, $sformatf("vec%0d", i), dec, s9, len);
      chk($sformatf("vec%0d data", i), 32'(dec), 32'(vt[i].d));
      chk($sformatf("vec%0d slot9", i), 32'(s9), 32'(vt[i].exp_s9));
      chk($sformatf("vec%0d frame len", i), 32'(len), 32'(vt[i].exp_len));
    end

    // Back-to-back with valid held: no gap beyond stop + 1 cycle, no duplicate
    send(0, 8'hA5, "b2b0");
    frame_check(0, 8'hA5, 1, 8'h3C, "b2b0", dec, s9, len);
    chk("b2b0 data", 32'(dec), 32'hA5);
    frame_check(0, 8'h3C, 0, 8'h00, "b2b1", dec, s9, len);
    chk("b2b1 data", 32'(dec), 32'h3C);
    idle_check(0, 3 * C, "b2b no extra frame");

    // Valid/data jitter while busy; 0xFF follows only because valid is high at ready
    send(0, 8'h5A, "busy0");
    frame_check(0, 8'h5A, 2, 8'hFF, "busy0", dec, s9, len);
    chk("busy0 data", 32'(dec), 32'h5A);
    frame_check(0, 8'hFF, 0, 8'h00, "busy1", dec, s9, len);
    chk("busy1 data", 32'(dec), 32'hFF);
    send(1, 8'hC3, "busy2");
    frame_check(1, 8'hC3, 3, 8'hFF, "busy2", dec, s9, len);
    chk("busy2 data", 32'(dec), 32'hC3);
    idle_check(1, 2 * C, "busy2 dropped byte not sent");

    // Reset in the middle of a frame
    send(0, 8'h00, "rstmid");
    for (int k = 0; k <= 35; k++) begin
      @(negedge clk);
      if (k == 0) valid_v[0] = 1'b0;
      if (k == 34) chk("rstmid pin low", 32'(pin_v[0]), 32'd0);
    end
    rst_v[0] = 1'b1;
    @(negedge clk);
    chk("rstmid pin", 32'(pin_v[0]), 32'd1);
    chk("rstmid busy", 32'(busy_v[0]), 32'd0);
    chk("rstmid ready", 32'(ready_v[0]), 32'd0);
    rst_v[0] = 1'b0;
    @(negedge clk);
    chk("rstmid ready after", 32'(ready_v[0]), 32'd1);
    idle_check(0, C, "rstmid abandoned");
    send(0, 8'h81, "after rst");
    frame_check(0, 8'h81, 0, 8'h00, "after rst", dec, s9, len);
    chk("after rst data", 32'(dec), 32'h81);

    // Randomized frames against the model
    for (int r = 0; r < 24; r++) begin
      idx = int'($urandom_range(0, 3));
      d   = 8'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      send(idx, d, $sformatf("rnd%0d", r));
      frame_check(idx, d, ($urandom_range(0, 1) == 1) ? 3 : 0, 8'($urandom),
                  $sformatf("rnd%0d", r), dec, s9, len);
      chk($sformatf("rnd%0d data", r), 32'(dec), 32'(d));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
